// File: rtl/meas_capture_fifo.sv
// meas_capture_fifo: show-ahead history FIFO of {sys_meas,temp} samples with freeze, sticky overrun and hysteresis alarm
module meas_capture_fifo #(
    parameter int TEMP_W   = 4,
    parameter int MEAS_W   = 2,
    parameter int DEPTH    = 4,
    parameter int ALARM_HI = 12,
    parameter int ALARM_LO = 10
) (
    input  logic                       clk,
    input  logic                       clr,
    input  logic [TEMP_W-1:0]          temp,
    input  logic [MEAS_W-1:0]          sys_meas,
    input  logic                       ld,
    input  logic                       st,
    input  logic                       rd,
    output logic [TEMP_W-1:0]          D_out,
    output logic [MEAS_W-1:0]          T_out,
    output logic                       valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       overrun,
    output logic                       alarm
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = TEMP_W + MEAS_W;
    localparam logic [CW-1:0]     FULL_C = CW'(DEPTH);
    localparam logic [TEMP_W-1:0] HI     = TEMP_W'(ALARM_HI);
    localparam logic [TEMP_W-1:0] LO     = TEMP_W'(ALARM_LO);

    typedef enum logic {IDLE = 1'b0, ALARM = 1'b1} alarm_state_t;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_count, w_cnt_nxt;
    logic          r_valid, r_full, r_overrun;
    logic          w_push_req, w_pop, w_push, w_drop;
    logic [EW-1:0] w_head;
    alarm_state_t  r_state, w_state_nxt;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        w_push_req = ld & ~st & ~clr;
        w_pop      = rd & r_valid & ~clr;
        w_push     = w_push_req & (~r_full | w_pop);
        w_drop     = w_push_req & r_full & ~w_pop;
        w_cnt_nxt  = r_count + CW'(w_push) - CW'(w_pop);
        w_head     = r_mem[r_rp];
    end

    // Sample storage is not cleared; only accepted pushes write it
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= {sys_meas, temp};
    end

    // Pointers, occupancy and flags; count is kept apart so full/empty never alias
    always_ff @(posedge clk) begin
        if (clr) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_count   <= '0;
            r_valid   <= 1'b0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push)
                r_wp <= r_wp + AW'(1);
            if (w_pop)
                r_rp <= r_rp + AW'(1);
            r_count   <= w_cnt_nxt;
            r_valid   <= w_cnt_nxt != '0;
            r_full    <= w_cnt_nxt == FULL_C;
            r_overrun <= r_overrun | w_drop;
        end
    end

    // Alarm state register
    always_ff @(posedge clk) begin
        if (clr)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Hysteresis: only accepted pushes move the alarm, using the pushed temperature
    always_comb begin
        w_state_nxt = r_state;
        if (w_push) begin
            if (r_state == IDLE && temp >= HI)
                w_state_nxt = ALARM;
            else if (r_state == ALARM && temp <= LO)
                w_state_nxt = IDLE;
        end
    end

    assign D_out   = r_valid ? w_head[TEMP_W-1:0] : '0;
    assign T_out   = r_valid ? w_head[EW-1:TEMP_W] : '0;
    assign valid   = r_valid;
    assign count   = r_count;
    assign full    = r_full;
    assign overrun = r_overrun;
    assign alarm   = r_state == ALARM;
endmodule
